// File: rtl/serial_negate_sequencer.sv
// Bit-serial two's-complement negator wrapped in a start/done sequencer; optional ovf output under OVERFLOW_FLAG_EN.
// Latency: start accepted at edge E, dout/done valid WIDTH edges later, next start at E+WIDTH+2.
// No backpressure: start is only looked at in IDLE, requests during busy/done are dropped.
module serial_negate_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             sout,
  output logic [WIDTH-1:0] dout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    count;
  logic             mode;
  logic             carry;
  logic             bit_in;
  logic             last;
`ifdef OVERFLOW_FLAG_EN
  logic             din_msb;
`endif

  // Negation as invert-then-increment: carry starts at 1 and dies at the first 0 of ~din.
  assign bit_in = shreg[0] ^ mode;
  assign sout   = bit_in ^ carry;
  assign last   = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      result  <= '0;
      count   <= '0;
      mode    <= 1'b0;
      carry   <= 1'b0;
      dout    <= '0;
`ifdef OVERFLOW_FLAG_EN
      din_msb <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= din;
            mode    <= neg;
            carry   <= neg;
            count   <= '0;
`ifdef OVERFLOW_FLAG_EN
            din_msb <= din[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          carry  <= bit_in & carry;
          result <= {sout, result[WIDTH-1:1]};
          shreg  <= shreg >> 1;
          count  <= count + CW'(1);
          // The bit committed on the final edge goes straight into dout.
          if (last) begin
            dout <= {sout, result[WIDTH-1:1]};
`ifdef OVERFLOW_FLAG_EN
            ovf  <= mode & din_msb & sout;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_negate_sequencer.sv
// Randomized self-checking bench for serial_negate_sequencer against a word-level negation model.
module tb_serial_negate_sequencer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         neg;
  logic [W-1:0] din;
  logic         busy;
  logic         done;
  logic         sout;
  logic [W-1:0] dout;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int           n_cmp;
  int           n_err;
  logic [W-1:0] last_dout;
  logic         last_ovf;

  serial_negate_sequencer #(.WIDTH(W), .CW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .neg   (neg),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .sout  (sout),
    .dout  (dout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input logic n);
    logic [W-1:0] r;
    r = n ? W'(0 - int'(d)) : d;
    return r;
  endfunction

  // Issue one operation and check every cycle until it completes.
  task automatic do_op(input logic [W-1:0] d, input logic n, input bit hold, input logic [W-1:0] junk);
    logic [W-1:0] exp;
    logic         exp_ovf;
    exp     = ref_result(d, n);
    exp_ovf = n & d[W-1] & exp[W-1];
    @(negedge clk);
    check_val("idle_busy", busy, 0);
    check_val("idle_done", done, 0);
    start = 1'b1;
    neg   = n;
    din   = d;
    @(posedge clk);
    #1;
    if (hold) begin
      din = junk;
      neg = ~n;
    end else begin
      start = 1'b0;
    end
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check_val("shift_busy", busy, 1);
      check_val("shift_done", done, 0);
      check_val("sout", sout, exp[i]);
      check_val("dout_hold", dout, last_dout);
    end
    @(negedge clk);
    check_val("done_pulse", done, 1);
    check_val("done_busy", busy, 0);
    check_val("dout", dout, exp);
`ifdef OVERFLOW_FLAG_EN
    check_val("ovf", ovf, exp_ovf);
`endif
    last_dout = exp;
    last_ovf  = exp_ovf;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    last_dout = '0;
    last_ovf  = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    neg       = 1'b0;
    din       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_sout", sout, 0);
    check_val("rst_dout", dout, 0);
`ifdef OVERFLOW_FLAG_EN
    check_val("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;

    // Directed cases from the corner list.
    do_op(8'h05, 1'b1, 1'b0, 8'h00);
    do_op(8'h00, 1'b1, 1'b0, 8'h00);
    do_op(8'h80, 1'b1, 1'b0, 8'h00);
    do_op(8'h7F, 1'b1, 1'b0, 8'h00);
    do_op(8'h3C, 1'b0, 1'b1, 8'hFF);
    @(negedge clk);
    start = 1'b0;
    check_val("no_restart", busy, 0);

    // Abort mid-operation with a one-cycle reset at the 4th shift edge.
    @(negedge clk);
    start = 1'b1;
    neg   = 1'b1;
    din   = 8'h05;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check_val("abort_busy", busy, 0);
      check_val("abort_done", done, 0);
      check_val("abort_dout", dout, 0);
    end
    last_dout = '0;
    last_ovf  = 1'b0;
    do_op(8'h01, 1'b1, 1'b0, 8'h00);

    // Back-to-back with start held high, then random traffic.
    for (int k = 0; k < 4; k++) begin
      do_op(W'($urandom), 1'($urandom), 1'b1, W'($urandom));
    end
    for (int k = 0; k < 30; k++) begin
      do_op(W'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    @(negedge clk);
    check_val("final_idle", busy, 0);
    check_val("final_dout", dout, last_dout);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_negate_sequencer.md
Name: serial_negate_sequencer

Overview:
Bit-serial word negator with a sequencing controller. Captures a parallel WIDTH-bit word on a start handshake and streams it LSB-first through an internal serial two's-complement stage (carry flip-flop plus inverter), one bit per clock. Reassembles the serial result into a parallel word and reports completion. Serves as the controller/wrapper that lets parallel logic use the serial complementer datapath.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32
CW, 5, counter width; must satisfy 2^CW > WIDTH

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  synchronous reset, active-high
start  input  1  request to process din; sampled only in IDLE
neg  input  1  1 = two's-complement negate, 0 = pass-through copy; sampled with start
din  input  WIDTH  operand; sampled with start
busy  output  1  high while state == SHIFT
done  output  1  one-cycle pulse; dout valid in the same cycle
sout  output  1  current serial output bit; meaningful while busy
dout  output  WIDTH  last completed result; held until the next completion

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. rst has priority over every other input at the clock edge.
- Reset values: state=IDLE, busy=0, done=0, sout=0, dout=0, count=0, carry=0, shift and result registers = 0.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at an edge:
  - load shreg<=din, mode<=neg, carry<=neg, count<=0, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, each edge:
  - bit b = shreg[0] XOR mode.
  - out = b XOR carry; carry <= b AND carry.
  - result <= {out, result[WIDTH-1:1]}; shreg >>= 1; count++.
  - When count == WIDTH-1 at the edge: go to DONE and dout <= final assembled word, including the bit produced at that edge.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE unconditionally. start is ignored in DONE.
- sout is combinational from the current shreg[0], mode and carry. It equals the bit being committed at the next edge.
- Latency: start accepted at edge E; busy high for WIDTH cycles after E; done high in cycle E+WIDTH+1; new start accepted at edge E+WIDTH+2 at the earliest.
- start, neg and din changes while busy or in DONE have no effect; no queuing.
- Arithmetic: result = (~din + 1) mod 2^WIDTH when neg=1, din when neg=0. Carry never propagates out of the word.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and dout is cleared to 0.
- dout is unchanged between completions, including during SHIFT.

Optional Feature:
OVERFLOW_FLAG_EN
- When defined: adds output port ovf (1 bit, reset 0).
  - Updated at the DONE entry edge together with dout.
  - ovf = mode AND din_msb AND result_msb, i.e. negation of the most negative value; din_msb is captured at start.
  - ovf holds until the next completion or reset.
- When undefined: no ovf port, and no din_msb capture flop.

Test Plan:
- WIDTH=8, reset then start=1, neg=1, din=0x05 -> busy for 8 cycles; sout sequence LSB-first 1,1,0,1,1,1,1,1; done one cycle later with dout=0xFB.
- neg=1, din=0x00 -> dout=0x00, carry stays 1 throughout, done pulse after 9 cycles; with OVERFLOW_FLAG_EN, ovf=0.
- neg=1, din=0x80 -> dout=0x80; with OVERFLOW_FLAG_EN, ovf=1. Follow-up din=0x7F -> dout=0x81, ovf=0.
- neg=0, din=0x3C -> dout=0x3C. Start held high through SHIFT with din=0xFF -> ignored; exactly one done pulse.
- Start din=0x05, neg=1; assert rst for one cycle at the 4th shift edge -> busy=0, done never pulses, dout=0x00. Next start din=0x01 -> dout=0xFF.
- Back-to-back: start held continuously high -> operations accepted every WIDTH+2 cycles. Each dout is correct, and done never overlaps busy.
